// File: rtl/wallace_pkg.sv
// wallace_pkg: sizing helpers and Baugh-Wooley constants shared by the Wallace multiplier
package wallace_pkg;

    localparam int MAX_W = 32;

    function automatic int rows_at(input int n, input int l);
        int r;
        r = n;
        for (int i = 0; i < l; i++) if (r > 2) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    function automatic int red_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            l++;
        end
        return l;
    endfunction

    // Signed-mode correction row: ones at bit w and bit 2w-1
    function automatic logic [2*MAX_W-1:0] bw_corr(input int w);
        return (64'd1 << w) | (64'd1 << (2 * w - 1));
    endfunction

endpackage

// File: rtl/csa_row.sv
// csa_row: row of full adders compressing three rows into a sum row and a pre-shifted carry row
module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] c_o
);
    assign s_o = x_i ^ y_i ^ z_i;
    assign c_o = (x_i & y_i | x_i & z_i | y_i & z_i) << 1;
endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: three-stage Wallace-tree multiplier, unsigned or Baugh-Wooley signed per operation
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int PW = 2 * WIDTH;
    localparam int NR = WIDTH + 1;
    localparam int LV = red_levels(NR);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
    localparam logic [PW-1:0] CORR = PW'(bw_corr(WIDTH));

    logic s1_v_q, s2_v_q, s3_v_q, sg_q, stall;
    logic [WIDTH-1:0] a_q, b_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [PW-1:0] sum_d, car_d, sum_q, car_q, p_d, p_q;

    assign stall = s3_v_q && !out_ready;
    assign in_ready = !stall;
    assign out_valid = s3_v_q;
    assign out_p = p_q;
    assign out_tag = tag3_q;

    for (genvar l = 0; l <= LV; l++) begin : lv
        localparam int N = rows_at(NR, l);
        logic [PW-1:0] r [N];
        if (l == 0) begin : g0
            for (genvar k = 0; k < WIDTH; k++) begin : p
                localparam logic [WIDTH-1:0] INV = (k == WIDTH - 1) ? ~MSB : MSB;
                assign r[k] = PW'((a_q & {WIDTH{b_q[k]}}) ^ (sg_q ? INV : '0)) << k;
            end
            assign r[WIDTH] = sg_q ? CORR : '0;
        end else begin : gn
            localparam int M = rows_at(NR, l - 1);
            localparam int G = M / 3;
            for (genvar g = 0; g < G; g++) begin : c
                csa_row #(.W(PW)) u_csa (
                    .x_i(lv[l-1].r[3*g]),
                    .y_i(lv[l-1].r[3*g+1]),
                    .z_i(lv[l-1].r[3*g+2]),
                    .s_o(r[2*g]),
                    .c_o(r[2*g+1])
                );
            end
            for (genvar k = 0; k < M % 3; k++) begin : t
                assign r[2*G+k] = lv[l-1].r[3*G+k];
            end
        end
    end

    assign sum_d = lv[LV].r[0];
    assign car_d = lv[LV].r[1];
    assign p_d = sum_q + car_q;

    // Pipeline registers: the whole pipe advances together unless the output is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            p_q <= '0;
            tag3_q <= '0;
        end else if (!stall) begin
            s1_v_q <= in_valid;
            a_q <= in_a;
            b_q <= in_b;
            sg_q <= in_signed;
            tag1_q <= in_tag;
            s2_v_q <= s1_v_q;
            sum_q <= sum_d;
            car_q <= car_d;
            tag2_q <= tag1_q;
            s3_v_q <= s2_v_q;
            p_q <= p_d;
            tag3_q <= tag2_q;
        end
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed, streaming, backpressure, reset and random checks of the multiplier
module tb_wallace_mult_pipe;
    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic in_ready;
    logic [7:0] in_a = 0;
    logic [7:0] in_b = 0;
    logic in_signed = 0;
    logic [3:0] in_tag = 0;
    logic out_valid;
    logic out_ready = 1;
    logic [15:0] out_p;
    logic [3:0] out_tag;

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    bit mon_en = 0;

    typedef struct packed {
        logic [15:0] p;
        logic [3:0] tag;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic sg;
        logic [3:0] tag;
        logic [15:0] p;
    } vec_t;
    vec_t vt[12];

    wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_p(input logic [7:0] a, input logic [7:0] b, input logic sg);
        logic [15:0] ua, ub;
        logic signed [15:0] sa, sb;
        ua = {8'h00, a};
        ub = {8'h00, b};
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        return sg ? 16'(sa * sb) : 16'(ua * ub);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sg, input logic [3:0] tag);
        in_valid = 1;
        in_a = a;
        in_b = b;
        in_signed = sg;
        in_tag = tag;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic sg, input logic [3:0] tag);
        q.push_back('{p: ref_p(a, b, sg), tag: tag});
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            xfers++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got_p=%0h got_tag=%0h want=none", out_p, out_tag);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("stream_p", {16'h0, out_p}, {16'h0, e.p});
                chk("stream_tag", {28'h0, out_tag}, {28'h0, e.tag});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int xf0;
        logic [15:0] held_p;
        logic [3:0] held_t;
        bit acc;
        vt[0]  = '{8'hFF, 8'hFF, 1'b0, 4'd3,  16'hFE01};
        vt[1]  = '{8'h00, 8'hA5, 1'b0, 4'd1,  16'h0000};
        vt[2]  = '{8'h80, 8'h80, 1'b1, 4'd2,  16'h4000};
        vt[3]  = '{8'hFF, 8'h01, 1'b1, 4'd4,  16'hFFFF};
        vt[4]  = '{8'h7F, 8'h80, 1'b1, 4'd5,  16'hC080};
        vt[5]  = '{8'hFF, 8'hFF, 1'b1, 4'd6,  16'h0001};
        vt[6]  = '{8'h80, 8'h01, 1'b1, 4'd7,  16'hFF80};
        vt[7]  = '{8'h7F, 8'h80, 1'b0, 4'd8,  16'h3F80};
        vt[8]  = '{8'h0F, 8'h0F, 1'b0, 4'd9,  16'h00E1};
        vt[9]  = '{8'h80, 8'h7F, 1'b1, 4'd10, 16'hC080};
        vt[10] = '{8'hFE, 8'h03, 1'b1, 4'd11, 16'hFFFA};
        vt[11] = '{8'h0C, 8'h0A, 1'b0, 4'd12, 16'h0078};

        step();
        step();
        rst = 0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_p", out_p, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_in_ready", in_ready, 1);

        foreach (vt[i]) begin
            drive(vt[i].a, vt[i].b, vt[i].sg, vt[i].tag);
            chk("vec_in_ready", in_ready, 1);
            step();
            in_valid = 0;
            chk("vec_lat1_valid", out_valid, 0);
            step();
            chk("vec_lat2_valid", out_valid, 0);
            step();
            chk("vec_lat3_valid", out_valid, 1);
            chk("vec_p", out_p, vt[i].p);
            chk("vec_tag", out_tag, vt[i].tag);
            step();
        end

        mon_en = 1;
        xf0 = xfers;
        for (int i = 0; i < 10; i++) begin
            drive(8'(i * 17 + 3), 8'(i * 29 + 200), i[0], 4'(i));
            chk("stream_in_ready", in_ready, 1);
            push(in_a, in_b, in_signed, in_tag);
            step();
        end
        in_valid = 0;
        repeat (3) step();
        chk("stream_count", xfers - xf0, 10);
        chk("stream_left", q.size(), 0);

        out_ready = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(8'(8'h81 + i * 37), 8'(8'h7E - i * 51), ~i[0], 4'(i + 4));
            chk("bp_fill_ready", in_ready, 1);
            push(in_a, in_b, in_signed, in_tag);
            step();
        end
        drive(8'h80, 8'hFF, 1'b1, 4'd9);
        held_p = out_p;
        held_t = out_tag;
        chk("bp_first_p", out_p, q[0].p);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_p_frozen", out_p, held_p);
            chk("bp_tag_frozen", out_tag, held_t);
            step();
        end
        xf0 = xfers;
        out_ready = 1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        push(in_a, in_b, in_signed, in_tag);
        step();
        in_valid = 0;
        drain();
        chk("bp_count", xfers - xf0, 4);

        out_ready = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(8'(8'h33 + i), 8'h44, 1'b0, 4'(i + 12));
            step();
        end
        rst = 1;
        step();
        rst = 0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_p", out_p, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        in_valid = 0;
        out_ready = 1;
        q.delete();
        xf0 = xfers;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_no_result", out_valid, 0);
        end
        chk("rst_dropped", xfers - xf0, 0);

        for (int c = 0; c < 3000; c++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if (!in_valid && $urandom_range(0, 3) != 0)
                drive(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            #1;
            acc = in_valid && in_ready;
            if (acc) push(in_a, in_b, in_signed, in_tag);
            step();
            if (acc) in_valid = 0;
        end
        in_valid = 0;
        out_ready = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
